// File: rtl/div_always.sv
// Sequential restoring divider: start/valid/busy responder, WIDTH iterations per operation.
// Define SIGNED_DIV_EN for two's-complement operands (truncating quotient, remainder takes dividend sign).
module div_always #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  input  logic             clk,
  input  logic             start,
  input  logic             reset,
  output logic             valid,
  output logic             busy,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_b_in;
  logic [WIDTH-1:0] w_x_fin;
  logic [WIDTH-1:0] w_r_fin;

`ifdef SIGNED_DIV_EN
  logic r_sign_q;
  logic r_sign_r;

  always_comb begin
    w_a_in = a[WIDTH-1] ? -a : a;
    w_b_in = b[WIDTH-1] ? -b : b;
    // Zero divisor keeps the raw all-ones quotient; the remainder re-signs back to a.
    w_x_fin = (r_sign_q && (r_div != '0)) ? -w_q_nxt : w_q_nxt;
    w_r_fin = r_sign_r ? -w_rem_nxt : w_rem_nxt;
  end
`else
  always_comb begin
    w_a_in  = a;
    w_b_in  = b;
    w_x_fin = w_q_nxt;
    w_r_fin = w_rem_nxt;
  end
`endif

  // Subtraction is taken W bits wide: when the compare passes the true difference is < 2^WIDTH.
  always_comb begin
    w_shift   = {r_rem, r_q[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_div});
    w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
    w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      x           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      valid       <= 1'b0;
      busy        <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q     <= w_a_in;
            r_div   <= w_b_in;
            r_rem   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
`ifdef SIGNED_DIV_EN
            r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            r_sign_r <= a[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            x           <= w_x_fin;
            r           <= w_r_fin;
            div_by_zero <= (r_div == '0);
            busy        <= 1'b0;
            valid       <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_always.sv
// Directed-vector bench for div_always: latency, busy window, divide by zero, ignored start,
// back-to-back, mid-operation reset and (with SIGNED_DIV_EN) signed vectors.
module tb_div_always;

  localparam int W = 32;

  logic [W-1:0] a, b, x, r;
  logic         clk, start, reset, valid, busy, div_by_zero;

  int errors = 0;
  int checks = 0;

  div_always #(.WIDTH(W), .CNT_W(6)) dut (
    .a(a), .b(b), .x(x), .clk(clk), .start(start), .reset(reset),
    .valid(valid), .busy(busy), .r(r), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb);
    a = aa; b = bb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges from the start-sampling edge until valid; busy samples counted along the way.
  task automatic wait_valid(output int n, output int nbusy);
    n = 0; nbusy = 0;
    while (!valid && n < 100) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
  endtask

  task automatic count_valid(input int cycles, output int nv);
    nv = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (valid) nv++;
    end
  endtask

  int n, nb, nv;

  initial begin
    a = '0; b = '0; start = 1'b0; reset = 1'b1;
    tick(); tick();
    check("rst_x", x, 0);
    check("rst_r", r, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_dbz", {31'd0, div_by_zero}, 0);
    reset = 1'b0;
    tick();

    // 100 / 7
    start_op(32'd100, 32'd7);
    check("basic_busy_start", {31'd0, busy}, 1);
    wait_valid(n, nb);
    check("basic_latency", n, 32);
    check("basic_busy_cycles", nb, 32);
    check("basic_x", x, 14);
    check("basic_r", r, 2);
    check("basic_dbz", {31'd0, div_by_zero}, 0);
    check("basic_busy_done", {31'd0, busy}, 0);
    tick();
    check("basic_valid_1cyc", {31'd0, valid}, 0);
    check("basic_x_hold", x, 14);

    // divide by zero
    start_op(32'h0000_1234, 32'd0);
    wait_valid(n, nb);
    check("dbz_latency", n, 32);
    check("dbz_x", x, 32'hFFFF_FFFF);
    check("dbz_r", r, 32'h0000_1234);
    check("dbz_flag", {31'd0, div_by_zero}, 1);
    count_valid(5, nv);
    check("dbz_single_valid", nv, 0);

    // start while busy is ignored
    start_op(32'd1000, 32'd10);
    for (int i = 0; i < 9; i++) tick();
    start_op(32'd5, 32'd5);
    wait_valid(n, nb);
    check("busy_start_latency", n + 10, 32);
    check("busy_start_x", x, 100);
    check("busy_start_r", r, 0);
    check("busy_start_dbz", {31'd0, div_by_zero}, 0);
    count_valid(40, nv);
    check("busy_start_no_2nd", nv, 0);

`ifndef SIGNED_DIV_EN
    // back-to-back: restart in the valid cycle
    start_op(32'hFFFF_FFFF, 32'h10);
    wait_valid(n, nb);
    check("b2b_first_latency", n, 32);
    check("b2b_first_x", x, 32'h0FFF_FFFF);
    check("b2b_first_r", r, 32'hF);
    start_op(32'd9, 32'd3);
    check("b2b_second_busy", {31'd0, busy}, 1);
    check("b2b_x_held", x, 32'h0FFF_FFFF);
    wait_valid(n, nb);
    check("b2b_second_latency", n, 32);
    check("b2b_second_x", x, 3);
    check("b2b_second_r", r, 0);
`endif

    // reset mid-operation
    start_op(32'd50, 32'd5);
    for (int i = 0; i < 14; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_x", x, 0);
    check("midrst_r", r, 0);
    count_valid(40, nv);
    check("midrst_no_valid", nv, 0);
    start_op(32'd50, 32'd5);
    wait_valid(n, nb);
    check("midrst_again_latency", n, 32);
    check("midrst_again_x", x, 10);
    check("midrst_again_r", r, 0);

`ifdef SIGNED_DIV_EN
    tick();
    start_op(32'hFFFF_FFF9, 32'd2);
    wait_valid(n, nb);
    check("sgn_latency", n, 32);
    check("sgn_x", x, 32'hFFFF_FFFD);
    check("sgn_r", r, 32'hFFFF_FFFF);
    tick();
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(n, nb);
    check("sgn_min_x", x, 32'h8000_0000);
    check("sgn_min_r", r, 0);
    tick();
    start_op(32'hFFFF_FFF9, 32'd0);
    wait_valid(n, nb);
    check("sgn_dbz_x", x, 32'hFFFF_FFFF);
    check("sgn_dbz_r", r, 32'hFFFF_FFF9);
    check("sgn_dbz_flag", {31'd0, div_by_zero}, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
